// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
// Single-word request/ready port toward the CPU, line-wide memory port with
// a fixed access latency, and saturating hit/miss counters.
module data_cache #(
   parameter int WORD_SIZE   = 16,
   parameter int LINES       = 8,
   parameter int MEM_LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   c_read,
   input  logic                   c_write,
   input  logic [WORD_SIZE-1:0]   c_address,
   input  logic [WORD_SIZE-1:0]   c_wdata,
   output logic [WORD_SIZE-1:0]   c_rdata,
   output logic                   c_ready,
   output logic                   d_readM,
   output logic                   d_writeM,
   output logic [WORD_SIZE-1:0]   d_address,
   inout  wire  [4*WORD_SIZE-1:0] d_data,
   output logic [15:0]            hit_count,
   output logic [15:0]            miss_count
);

   localparam int IW = $clog2(LINES);
   localparam int TW = WORD_SIZE - IW - 2;
   localparam int LW = 4 * WORD_SIZE;
   localparam int CW = $clog2(MEM_LATENCY) + 1;
   localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

   state_t                 state_q, state_d;
   logic [LINES-1:0]       valid_q, valid_d;
   logic [TW-1:0]          tag_q  [LINES];
   logic [TW-1:0]          tag_d  [LINES];
   logic [LW-1:0]          data_q [LINES];
   logic [LW-1:0]          data_d [LINES];
   logic [WORD_SIZE-1:0]   rdata_q, rdata_d;
   logic                   ready_q, ready_d;
   logic                   readm_q, readm_d;
   logic                   writem_q, writem_d;
   logic [WORD_SIZE-1:0]   daddr_q, daddr_d;
   logic [WORD_SIZE-1:0]   addr_q, addr_d;
   logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
   logic [15:0]            hit_count_q, hit_count_d;
   logic [15:0]            miss_count_q, miss_count_d;
   logic [CW-1:0]          cnt_q, cnt_d;

   // Live request fields (IDLE) and latched request fields (during FILL)
   logic [IW-1:0] c_idx, f_idx;
   logic [TW-1:0] c_tag, f_tag;
   logic [1:0]    c_off, f_off;
   logic          c_hit, last_cyc;

   assign c_idx    = c_address[IW+1:2];
   assign c_tag    = c_address[WORD_SIZE-1:IW+2];
   assign c_off    = c_address[1:0];
   assign f_idx    = addr_q[IW+1:2];
   assign f_tag    = addr_q[WORD_SIZE-1:IW+2];
   assign f_off    = addr_q[1:0];
   assign c_hit    = valid_q[c_idx] && (tag_q[c_idx] == c_tag);
   assign last_cyc = (cnt_q == LAST);

   // Memory bus is only driven for the duration of a word write
   assign d_data     = writem_q ? {{(3*WORD_SIZE){1'b0}}, wdata_q} : {LW{1'bz}};
   assign c_rdata    = rdata_q;
   assign c_ready    = ready_q;
   assign d_readM    = readm_q;
   assign d_writeM   = writem_q;
   assign d_address  = daddr_q;
   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; a simultaneous read+write is handled as a write
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (c_write)     state_d = WRITE;
                  else if (c_read) state_d = c_hit ? RESP : FILL;
         FILL:    if (last_cyc)    state_d = RESP;
         WRITE:   if (last_cyc)    state_d = RESP;
         default:                  state_d = IDLE;
      endcase
   end

   // Datapath and registered outputs; strobes follow the next state so they
   // are high exactly while the FSM sits in FILL/WRITE/RESP
   always_comb begin
      valid_d      = valid_q;
      tag_d        = tag_q;
      data_d       = data_q;
      rdata_d      = rdata_q;
      daddr_d      = daddr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      cnt_d        = cnt_q + 1'b1;
      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            addr_d = c_address;
            wdata_d = c_wdata;
            if (c_write || c_read) begin
               if (c_hit) hit_count_d  = (hit_count_q  == 16'hFFFF) ? hit_count_q  : hit_count_q  + 16'd1;
               else       miss_count_d = (miss_count_q == 16'hFFFF) ? miss_count_q : miss_count_q + 16'd1;
            end
            if (c_write) begin
               daddr_d = c_address;
               if (c_hit) data_d[c_idx][c_off*WORD_SIZE +: WORD_SIZE] = c_wdata;
            end else if (c_read) begin
               if (c_hit) rdata_d = data_q[c_idx][c_off*WORD_SIZE +: WORD_SIZE];
               else       daddr_d = {c_address[WORD_SIZE-1:2], 2'b00};
            end
         end
         FILL: begin
            if (last_cyc) begin
               data_d[f_idx]  = d_data;
               valid_d[f_idx] = 1'b1;
               tag_d[f_idx]   = f_tag;
               rdata_d        = d_data[f_off*WORD_SIZE +: WORD_SIZE];
            end
         end
         default: ;
      endcase
      ready_d  = (state_d == RESP);
      readm_d  = (state_d == FILL);
      writem_d = (state_d == WRITE);
   end

   // Control/output registers; reset aborts any in-flight memory access
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q      <= '0;
         rdata_q      <= '0;
         ready_q      <= 1'b0;
         readm_q      <= 1'b0;
         writem_q     <= 1'b0;
         daddr_q      <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
         cnt_q        <= '0;
      end else begin
         valid_q      <= valid_d;
         rdata_q      <= rdata_d;
         ready_q      <= ready_d;
         readm_q      <= readm_d;
         writem_q     <= writem_d;
         daddr_q      <= daddr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
         cnt_q        <= cnt_d;
      end
   end

   // Tag/data storage; contents are meaningless while the valid bit is clear
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed tests for data_cache with a small line memory model.
module tb_data_cache;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        c_read = 1'b0;
   logic        c_write = 1'b0;
   logic [15:0] c_address = 16'h0;
   logic [15:0] c_wdata = 16'h0;
   wire  [15:0] c_rdata;
   wire         c_ready;
   wire         d_readM;
   wire         d_writeM;
   wire  [15:0] d_address;
   wire  [63:0] d_data;
   wire  [15:0] hit_count;
   wire  [15:0] miss_count;

   int checks = 0;
   int errors = 0;
   int overlap = 0;

   logic [15:0] mem [0:511];
   bit          wr_vld [0:511];
   logic [63:0] line_r = 64'h0;

   data_cache dut (
      .clk(clk), .reset(reset),
      .c_read(c_read), .c_write(c_write), .c_address(c_address), .c_wdata(c_wdata),
      .c_rdata(c_rdata), .c_ready(c_ready),
      .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_data(d_data),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   // Memory image: line 0x20 holds 0x6000 in word 3 and zeros elsewhere,
   // every other word defaults to 0xC000|addr until written.
   function automatic logic [15:0] mem_rd(input logic [15:0] a);
      if (wr_vld[a[8:0]])       return mem[a[8:0]];
      if (a == 16'h0023)        return 16'h6000;
      if (a[15:2] == 14'h0008)  return 16'h0000;
      return 16'hC000 | a;
   endfunction

   always @(negedge clk)
      line_r <= {mem_rd({d_address[15:2], 2'd3}), mem_rd({d_address[15:2], 2'd2}),
                 mem_rd({d_address[15:2], 2'd1}), mem_rd({d_address[15:2], 2'd0})};

   assign d_data = d_readM ? line_r : 64'bz;

   always @(posedge clk)
      if (d_writeM) begin
         mem[d_address[8:0]]    <= d_data[15:0];
         wr_vld[d_address[8:0]] <= 1'b1;
      end

   always @(negedge clk)
      if (d_readM && d_writeM) overlap <= overlap + 1;

   // Issue one request and observe it until c_ready (bounded); lat=-1 on timeout
   task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wd, output int lat, output int nrd,
                         output int nwr, output logic [15:0] rdata,
                         output logic [15:0] maddr, output logic [15:0] mdat);
      lat = -1; nrd = 0; nwr = 0; rdata = '0; maddr = '0; mdat = '0;
      @(negedge clk);
      c_read = rd; c_write = wr; c_address = addr; c_wdata = wd;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (d_readM)  begin nrd++; maddr = d_address; end
         if (d_writeM) begin nwr++; maddr = d_address; mdat = d_data[15:0]; end
         if (c_ready)  begin lat = i; rdata = c_rdata; break; end
      end
      c_read = 1'b0; c_write = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (c_ready !== 1'b0)       begin errors++; $display("FAIL reset_ready got %0h want 0", c_ready); end
      checks++; if (c_rdata !== 16'h0)      begin errors++; $display("FAIL reset_rdata got %0h want 0", c_rdata); end
      checks++; if (d_readM !== 1'b0)       begin errors++; $display("FAIL reset_readM got %0h want 0", d_readM); end
      checks++; if (d_writeM !== 1'b0)      begin errors++; $display("FAIL reset_writeM got %0h want 0", d_writeM); end
      checks++; if (d_address !== 16'h0)    begin errors++; $display("FAIL reset_daddr got %0h want 0", d_address); end
      checks++; if (hit_count !== 16'h0)    begin errors++; $display("FAIL reset_hits got %0h want 0", hit_count); end
      checks++; if (miss_count !== 16'h0)   begin errors++; $display("FAIL reset_misses got %0h want 0", miss_count); end
      reset = 1'b0;
   endtask

   task automatic test_read_miss();
      int lat, nrd, nwr; logic [15:0] rd, ma, md;
      do_req(1'b1, 1'b0, 16'h0023, 16'h0, lat, nrd, nwr, rd, ma, md);
      checks++; if (lat !== 3)              begin errors++; $display("FAIL miss_latency got %0d want 3", lat); end
      checks++; if (nrd !== 2)              begin errors++; $display("FAIL miss_readM_cycles got %0d want 2", nrd); end
      checks++; if (nwr !== 0)              begin errors++; $display("FAIL miss_writeM_cycles got %0d want 0", nwr); end
      checks++; if (ma !== 16'h0020)        begin errors++; $display("FAIL miss_daddr got %0h want 0020", ma); end
      checks++; if (rd !== 16'h6000)        begin errors++; $display("FAIL miss_rdata got %0h want 6000", rd); end
      checks++; if (miss_count !== 16'd1)   begin errors++; $display("FAIL miss_count1 got %0d want 1", miss_count); end
   endtask

   task automatic test_read_hit();
      int lat, nrd, nwr; logic [15:0] rd, ma, md;
      for (int a = 16'h20; a <= 16'h22; a++) begin
         do_req(1'b1, 1'b0, 16'(a), 16'h0, lat, nrd, nwr, rd, ma, md);
         checks++; if (lat !== 1)           begin errors++; $display("FAIL hit_latency @%0h got %0d want 1", a, lat); end
         checks++; if (nrd !== 0)           begin errors++; $display("FAIL hit_readM @%0h got %0d want 0", a, nrd); end
         checks++; if (rd !== 16'h0)        begin errors++; $display("FAIL hit_rdata @%0h got %0h want 0", a, rd); end
      end
      checks++; if (hit_count !== 16'd3)    begin errors++; $display("FAIL hit_count3 got %0d want 3", hit_count); end
   endtask

   task automatic test_write_hit();
      int lat, nrd, nwr; logic [15:0] rd, ma, md;
      do_req(1'b0, 1'b1, 16'h0021, 16'h5A5A, lat, nrd, nwr, rd, ma, md);
      checks++; if (lat !== 3)              begin errors++; $display("FAIL wrhit_latency got %0d want 3", lat); end
      checks++; if (nwr !== 2)              begin errors++; $display("FAIL wrhit_writeM_cycles got %0d want 2", nwr); end
      checks++; if (nrd !== 0)              begin errors++; $display("FAIL wrhit_readM_cycles got %0d want 0", nrd); end
      checks++; if (ma !== 16'h0021)        begin errors++; $display("FAIL wrhit_daddr got %0h want 0021", ma); end
      checks++; if (md !== 16'h5A5A)        begin errors++; $display("FAIL wrhit_ddata got %0h want 5a5a", md); end
      checks++; if (mem_rd(16'h0021) !== 16'h5A5A) begin errors++; $display("FAIL wrhit_mem got %0h want 5a5a", mem_rd(16'h0021)); end
      checks++; if (hit_count !== 16'd4)    begin errors++; $display("FAIL wrhit_hits got %0d want 4", hit_count); end
      do_req(1'b1, 1'b0, 16'h0021, 16'h0, lat, nrd, nwr, rd, ma, md);
      checks++; if (lat !== 1)              begin errors++; $display("FAIL rdback_latency got %0d want 1", lat); end
      checks++; if (rd !== 16'h5A5A)        begin errors++; $display("FAIL rdback_rdata got %0h want 5a5a", rd); end
      checks++; if (hit_count !== 16'd5)    begin errors++; $display("FAIL rdback_hits got %0d want 5", hit_count); end
   endtask

   task automatic test_write_miss();
      int lat, nrd, nwr; logic [15:0] rd, ma, md;
      do_req(1'b1, 1'b1, 16'h0040, 16'h1234, lat, nrd, nwr, rd, ma, md);
      checks++; if (lat !== 3)              begin errors++; $display("FAIL wrmiss_latency got %0d want 3", lat); end
      checks++; if (nwr !== 2)              begin errors++; $display("FAIL wrmiss_writeM_cycles got %0d want 2", nwr); end
      checks++; if (nrd !== 0)              begin errors++; $display("FAIL wrmiss_readM_cycles got %0d want 0", nrd); end
      checks++; if (ma !== 16'h0040)        begin errors++; $display("FAIL wrmiss_daddr got %0h want 0040", ma); end
      checks++; if (miss_count !== 16'd2)   begin errors++; $display("FAIL wrmiss_count got %0d want 2", miss_count); end
      do_req(1'b1, 1'b0, 16'h0040, 16'h0, lat, nrd, nwr, rd, ma, md);
      checks++; if (lat !== 3)              begin errors++; $display("FAIL noalloc_latency got %0d want 3", lat); end
      checks++; if (nrd !== 2)              begin errors++; $display("FAIL noalloc_readM_cycles got %0d want 2", nrd); end
      checks++; if (rd !== 16'h1234)        begin errors++; $display("FAIL noalloc_rdata got %0h want 1234", rd); end
      checks++; if (miss_count !== 16'd3)   begin errors++; $display("FAIL noalloc_count got %0d want 3", miss_count); end
      checks++; if (hit_count !== 16'd5)    begin errors++; $display("FAIL noalloc_hits got %0d want 5", hit_count); end
   endtask

   task automatic test_conflict();
      int lat, nrd, nwr; logic [15:0] rd, ma, md;
      logic [15:0] seq [3];
      seq[0] = 16'h0024; seq[1] = 16'h0124; seq[2] = 16'h0024;
      for (int k = 0; k < 3; k++) begin
         do_req(1'b1, 1'b0, seq[k], 16'h0, lat, nrd, nwr, rd, ma, md);
         checks++; if (lat !== 3)           begin errors++; $display("FAIL evict_latency #%0d got %0d want 3", k, lat); end
         checks++; if (nrd !== 2)           begin errors++; $display("FAIL evict_readM #%0d got %0d want 2", k, nrd); end
         checks++; if (ma !== seq[k])       begin errors++; $display("FAIL evict_daddr #%0d got %0h want %0h", k, ma, seq[k]); end
         checks++; if (rd !== (16'hC000 | seq[k])) begin errors++; $display("FAIL evict_rdata #%0d got %0h want %0h", k, rd, 16'hC000 | seq[k]); end
      end
      checks++; if (miss_count !== 16'd6)   begin errors++; $display("FAIL evict_count got %0d want 6", miss_count); end
   endtask

   task automatic test_reset_mid_fill();
      int lat, nrd, nwr; logic [15:0] rd, ma, md;
      @(negedge clk);
      c_read = 1'b1; c_address = 16'h0030;
      @(negedge clk);
      checks++; if (d_readM !== 1'b1)       begin errors++; $display("FAIL abort_fill_started got %0h want 1", d_readM); end
      @(negedge clk);
      reset = 1'b1; c_read = 1'b0;
      @(negedge clk);
      checks++; if (d_readM !== 1'b0)       begin errors++; $display("FAIL abort_readM got %0h want 0", d_readM); end
      checks++; if (c_ready !== 1'b0)       begin errors++; $display("FAIL abort_ready got %0h want 0", c_ready); end
      checks++; if (hit_count !== 16'd0)    begin errors++; $display("FAIL abort_hits got %0d want 0", hit_count); end
      checks++; if (miss_count !== 16'd0)   begin errors++; $display("FAIL abort_misses got %0d want 0", miss_count); end
      reset = 1'b0;
      do_req(1'b1, 1'b0, 16'h0030, 16'h0, lat, nrd, nwr, rd, ma, md);
      checks++; if (lat !== 3)              begin errors++; $display("FAIL reread_latency got %0d want 3", lat); end
      checks++; if (nrd !== 2)              begin errors++; $display("FAIL reread_readM got %0d want 2", nrd); end
      checks++; if (rd !== 16'hC030)        begin errors++; $display("FAIL reread_rdata got %0h want c030", rd); end
      checks++; if (miss_count !== 16'd1)   begin errors++; $display("FAIL reread_misses got %0d want 1", miss_count); end
      do_req(1'b1, 1'b0, 16'h0023, 16'h0, lat, nrd, nwr, rd, ma, md);
      checks++; if (lat !== 3)              begin errors++; $display("FAIL invalidated_latency got %0d want 3", lat); end
      checks++; if (miss_count !== 16'd2)   begin errors++; $display("FAIL invalidated_misses got %0d want 2", miss_count); end
   endtask

   task automatic test_saturate();
      int lat, nrd, nwr; logic [15:0] rd, ma, md;
      do_req(1'b1, 1'b0, 16'h0030, 16'h0, lat, nrd, nwr, rd, ma, md);
      checks++; if (lat !== 1)              begin errors++; $display("FAIL sat_prehit_latency got %0d want 1", lat); end
      checks++; if (hit_count !== 16'd1)    begin errors++; $display("FAIL sat_prehit_hits got %0d want 1", hit_count); end
      @(negedge clk);
      force dut.hit_count_q = 16'hFFFF;
      #1 release dut.hit_count_q;
      do_req(1'b1, 1'b0, 16'h0031, 16'h0, lat, nrd, nwr, rd, ma, md);
      checks++; if (lat !== 1)              begin errors++; $display("FAIL sat_hit_latency got %0d want 1", lat); end
      checks++; if (rd !== 16'hC031)        begin errors++; $display("FAIL sat_hit_rdata got %0h want c031", rd); end
      checks++; if (hit_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hits got %0h want ffff", hit_count); end
      checks++; if (miss_count !== 16'd2)   begin errors++; $display("FAIL sat_misses got %0d want 2", miss_count); end
   endtask

   initial begin
      test_reset();
      test_read_miss();
      test_read_hit();
      test_write_hit();
      test_write_miss();
      test_conflict();
      test_reset_mid_fill();
      test_saturate();
      checks++; if (overlap !== 0) begin errors++; $display("FAIL strobe_overlap got %0d cycles want 0", overlap); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
